data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the core's load/store port: accepts the level-held `read_enable` / `write_enable` + `strb` request that the core's memory-access stage raises, and performs the byte-lane write or word read against a local word-organised RAM after a parameterised latency. It answers each request with a one-cycle `read_valid` / `write_ready` pulse, which releases the core's memory stall. It is used as data memory in simulation tops and small FPGA builds, and flags out-of-range or misaligned accesses as faults.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `READ_LATENCY`, 2: cycles from request acceptance to `read_valid`; range 1..15.
- `WRITE_LATENCY`, 1: cycles from request acceptance to `write_ready`; range 1..15.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, addressed byte/half in low lanes.
- `strb`  in  4  unshifted byte mask (0001 / 0011 / 1111).
- `write_enable`  in  1  store request, held until `write_ready`.
- `read_enable`  in  1  load request, held until `read_valid`.
- `write_ready`  out  1  store-complete pulse.
- `read_valid`  out  1  load-data-valid pulse.
- `rdata`  out  32  load data, addressed byte in lane 0.
- `access_fault`  out  1  valid only with `write_ready`/`read_valid`; request rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if either enable is high at a rising edge, latch `addr`, `wdata`, `strb`, kind (read/write/both), and load counter with latency−1. Go to RESP if the latency is 1, else WAIT.
- WAIT: decrement counter each cycle. Move to RESP when the counter reaches 0.
- RESP: assert exactly one of `write_ready`/`read_valid` for one cycle, then return to IDLE. Requests are not sampled in RESP.
- Effective strobe = `strb << addr[1:0]`. Shifted write data = `wdata << 8*addr[1:0]`.
- Fault when any of:
  - `addr` is outside `[BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)`;
  - the shifted strobe carries bits beyond lane 3 (e.g. SW at offset 1, SH at offset 3);
  - both enables are high at acceptance. The response is then `write_ready` with fault.
- A faulting request writes nothing and returns `rdata` = 0.
- Write commits at the rising edge ending the RESP cycle. Only lanes with effective strobe set are written.
- Read: array word is sampled on entry to RESP. `rdata` = word >> 8*addr[1:0]; upper lanes are not masked. `rdata` holds until the next read response.
- Dropping an enable after acceptance does not cancel the request.

## Timing
- Reset values: state IDLE, `write_ready`=0, `read_valid`=0, `access_fault`=0, `rdata`=0. The RAM array is not reset.
- Request high in cycle 0 while IDLE → response pulse in cycle L (L = applicable latency), held for exactly one cycle.
- Earliest next acceptance is cycle L+1. Back-to-back throughput is one access per L+1 cycles.
- An enable still high in cycle L+1 is a new request, because the core advances on the pulse.
- Read-after-write to the same word returns the new data when the read is accepted after the write's RESP cycle.
- `rst_n` low mid-operation: immediate return to IDLE with the reset output values. The in-flight write is dropped; the array is unchanged.

## Structure
- The FSM state enum and latency counter width (`$clog2(16)`) go in the shared `common` package, alongside the existing access-type constants.
- One sub-module, `byte_lane_ram`: `DEPTH_WORDS`×32 array with a 4-bit write-enable, one synchronous write port and one read port. It has no reset.
- Range, alignment and fault logic live in the top module.

## Test plan
- READ_LATENCY=2, WRITE_LATENCY=1: SW `wdata`=32'hDEADBEEF at `BASE_ADDR`+8, then LW same address.
  - `write_ready` pulse 1 cycle after acceptance.
  - `read_valid` 2 cycles after acceptance, `rdata`=32'hDEADBEEF, `access_fault`=0.
- SB `wdata`=32'h000000AA, `strb`=0001 at +9 over 32'hDEADBEEF; then LW +8 → 32'hDEADAAEF. Then LB at +9 → `rdata[7:0]`=8'hAA.
- SH at +3 (strb 0011) → `write_ready` with `access_fault`=1, and memory is unchanged.
- LW at `BASE_ADDR`+4*DEPTH_WORDS → `read_valid` with `access_fault`=1 and `rdata`=0.
- Enables held continuously for 3 back-to-back LWs with READ_LATENCY=1 → pulses in cycles 1, 3, 5; no duplicate responses.
- `rst_n` asserted in WAIT of a SW with WRITE_LATENCY=4 → outputs 0 immediately, no `write_ready`, and the target word keeps its prior value.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data memory responder: FSM states,
// latency counter width, access-kind encodings and strobe alignment.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int CNT_W = $clog2(16);

    // Access kind as {write_enable, read_enable}
    localparam logic [1:0] ACC_READ  = 2'b01;
    localparam logic [1:0] ACC_WRITE = 2'b10;
    localparam logic [1:0] ACC_BOTH  = 2'b11;

    // Low nibble is the lane mask, high nibble holds lanes pushed past lane 3.
    function automatic logic [7:0] shift_strobe(input logic [3:0] strb, input logic [1:0] off);
        return {4'b0000, strb} << off;
    endfunction

endpackage

// File: rtl/data_mem_responder_byte_lane_ram.sv
// Word-organised RAM with per-byte write enables, one synchronous write
// port and one asynchronous read port. Contents are not reset.
module byte_lane_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Byte-lane write port
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core load/store port: latches a request,
// waits the configured latency, then pulses write_ready or read_valid.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          READ_LATENCY  = 2,
    parameter int          WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  strb,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic        write_ready,
    output logic        read_valid,
    output logic [31:0] rdata,
    output logic        access_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0]      BASE_V    = BASE_ADDR;
    localparam logic [CNT_W-1:0] RD_LAT_M1 = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LAT_M1 = CNT_W'(WRITE_LATENCY - 1);

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [AW+1:0]    addr_r;
    logic [31:0]      wdata_r;
    logic [3:0]       strb_r;
    logic [1:0]       kind_r;
    logic             fault_r;
    logic             write_ready_r;
    logic             read_valid_r;
    logic             access_fault_r;
    logic [31:0]      rdata_r;

    logic             req_s;
    logic [7:0]       in_strb_s;
    logic             in_fault_s;
    logic [CNT_W-1:0] lat_m1_s;
    logic [AW+1:0]    cur_addr_s;
    logic             cur_write_s;
    logic             cur_fault_s;
    logic             go_resp_s;
    logic [7:0]       eff_strb_s;
    logic [3:0]       ram_we_s;
    logic [31:0]      ram_wdata_s;
    logic [31:0]      rword_s;
    logic [31:0]      read_shift_s;

    assign req_s      = read_enable | write_enable;
    assign in_strb_s  = shift_strobe(strb, addr[1:0]);
    // Base is aligned to the window size, so range is an upper-bit compare.
    assign in_fault_s = (addr[31:AW+2] != BASE_V[31:AW+2]) | (|in_strb_s[7:4])
                        | (read_enable & write_enable);
    assign lat_m1_s   = write_enable ? WR_LAT_M1 : RD_LAT_M1;

    // Current-request view: live inputs while accepting, latched copy afterwards
    always_comb begin
        cur_addr_s  = addr_r;
        cur_write_s = (kind_r != ACC_READ);
        cur_fault_s = fault_r;
        go_resp_s   = 1'b0;
        if (state_r == IDLE) begin
            cur_addr_s  = addr[AW+1:0];
            cur_write_s = write_enable;
            cur_fault_s = in_fault_s;
            go_resp_s   = req_s && (lat_m1_s == {CNT_W{1'b0}});
        end else if (state_r == WAIT) begin
            go_resp_s = (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1});
        end else begin
            go_resp_s = 1'b0;
        end
    end

    assign eff_strb_s   = shift_strobe(strb_r, addr_r[1:0]);
    assign ram_wdata_s  = wdata_r << {addr_r[1:0], 3'b000};
    assign read_shift_s = rword_s >> {cur_addr_s[1:0], 3'b000};

    // Commit lanes only on the RESP cycle of a non-faulting write
    always_comb begin
        ram_we_s = 4'b0000;
        if ((state_r == RESP) && (kind_r != ACC_READ) && !fault_r) begin
            ram_we_s = eff_strb_s[3:0];
        end else begin
            ram_we_s = 4'b0000;
        end
    end

    byte_lane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (addr_r[AW+1:2]),
        .wdata (ram_wdata_s),
        .raddr (cur_addr_s[AW+1:2]),
        .rdata (rword_s)
    );

    // Request FSM with registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            addr_r         <= {(AW+2){1'b0}};
            wdata_r        <= 32'h0000_0000;
            strb_r         <= 4'b0000;
            kind_r         <= 2'b00;
            fault_r        <= 1'b0;
            write_ready_r  <= 1'b0;
            read_valid_r   <= 1'b0;
            access_fault_r <= 1'b0;
            rdata_r        <= 32'h0000_0000;
        end else begin
            write_ready_r  <= 1'b0;
            read_valid_r   <= 1'b0;
            access_fault_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        addr_r  <= addr[AW+1:0];
                        wdata_r <= wdata;
                        strb_r  <= strb;
                        kind_r  <= {write_enable, read_enable};
                        fault_r <= in_fault_s;
                        cnt_r   <= lat_m1_s;
                        state_r <= go_resp_s ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (go_resp_s) begin
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RESP:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
            if (go_resp_s) begin
                write_ready_r  <= cur_write_s;
                read_valid_r   <= !cur_write_s;
                access_fault_r <= cur_fault_s;
                if (!cur_write_s) begin
                    rdata_r <= cur_fault_s ? 32'h0000_0000 : read_shift_s;
                end
            end
        end
    end

    assign write_ready  = write_ready_r;
    assign read_valid   = read_valid_r;
    assign access_fault = access_fault_r;
    assign rdata        = rdata_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance A (RL=2, WL=1) and
// instance B (RL=1, WL=4, 16 words) with hand-computed expectations.
module tb_data_mem_responder;

    localparam logic [31:0] BA = 32'h0001_0000;
    localparam logic [31:0] BB = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        a_rst_n, b_rst_n;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [3:0]  a_strb, b_strb;
    logic        a_we, a_re, b_we, b_re;
    logic        a_wr, a_rv, a_flt, b_wr, b_rv, b_flt;
    logic [31:0] a_rdata, b_rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BA), .READ_LATENCY(2), .WRITE_LATENCY(1)) u_a (
        .clk(clk), .rst_n(a_rst_n), .addr(a_addr), .wdata(a_wdata), .strb(a_strb),
        .write_enable(a_we), .read_enable(a_re), .write_ready(a_wr), .read_valid(a_rv),
        .rdata(a_rdata), .access_fault(a_flt));

    data_mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(BB), .READ_LATENCY(1), .WRITE_LATENCY(4)) u_b (
        .clk(clk), .rst_n(b_rst_n), .addr(b_addr), .wdata(b_wdata), .strb(b_strb),
        .write_enable(b_we), .read_enable(b_re), .write_ready(b_wr), .read_valid(b_rv),
        .rdata(b_rdata), .access_fault(b_flt));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit on_b, input logic we, input logic re,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] st);
        if (on_b) begin
            b_we = we; b_re = re; b_addr = ad; b_wdata = wd; b_strb = st;
        end else begin
            a_we = we; a_re = re; a_addr = ad; a_wdata = wd; a_strb = st;
        end
    endtask

    task automatic sample(input bit on_b, output logic wr, output logic rv,
                          output logic flt, output logic [31:0] rd);
        wr  = on_b ? b_wr    : a_wr;
        rv  = on_b ? b_rv    : a_rv;
        flt = on_b ? b_flt   : a_flt;
        rd  = on_b ? b_rdata : a_rdata;
    endtask

    // One request from an IDLE cycle: latency, pulse kind, fault, data, pulse width
    task automatic req(input bit on_b, input logic we, input logic re,
                       input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] st,
                       input int exp_lat, input logic exp_fault,
                       input logic chk_rd, input logic [31:0] exp_rd, input string tag);
        int n;
        logic wr, rv, flt;
        logic [31:0] rd;
        drive(on_b, we, re, ad, wd, st);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            sample(on_b, wr, rv, flt, rd);
        end while (!(wr | rv) && n < 20);
        drive(on_b, 1'b0, 1'b0, ad, wd, st);
        check({tag, ".lat"}, n, exp_lat);
        check({tag, ".write_ready"}, {31'd0, wr}, {31'd0, we});
        check({tag, ".read_valid"}, {31'd0, rv}, {31'd0, ~we});
        check({tag, ".fault"}, {31'd0, flt}, {31'd0, exp_fault});
        if (chk_rd) check({tag, ".rdata"}, rd, exp_rd);
        @(posedge clk); #1;
        sample(on_b, wr, rv, flt, rd);
        check({tag, ".pulse_end"}, {30'd0, wr, rv}, 32'd0);
    endtask

    initial begin
        logic wr, rv, flt;
        logic [31:0] rd;

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #2;
        check("rst.a", {a_wr, a_rv, a_flt, a_rdata[28:0]}, 32'd0);
        check("rst.a_rdata", a_rdata, 32'h0);
        check("rst.b", {b_wr, b_rv, b_flt, 29'd0}, 32'd0);
        check("rst.b_rdata", b_rdata, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(posedge clk); #1;

        // Instance A: RL=2, WL=1
        req(1'b0, 1'b1, 1'b0, BA + 32'd8,  32'hDEADBEEF, 4'b1111, 1, 1'b0, 1'b0, 32'h0, "a_sw8");
        req(1'b0, 1'b0, 1'b1, BA + 32'd8,  32'h0,        4'b1111, 2, 1'b0, 1'b1, 32'hDEADBEEF, "a_lw8");
        req(1'b0, 1'b1, 1'b0, BA + 32'd9,  32'h000000AA, 4'b0001, 1, 1'b0, 1'b0, 32'h0, "a_sb9");
        req(1'b0, 1'b0, 1'b1, BA + 32'd8,  32'h0,        4'b1111, 2, 1'b0, 1'b1, 32'hDEADAAEF, "a_lw8b");
        req(1'b0, 1'b0, 1'b1, BA + 32'd9,  32'h0,        4'b0001, 2, 1'b0, 1'b1, 32'h00DEADAA, "a_lb9");
        req(1'b0, 1'b0, 1'b1, BA + 32'd10, 32'h0,        4'b0011, 2, 1'b0, 1'b1, 32'h0000DEAD, "a_lh10");
        req(1'b0, 1'b1, 1'b0, BA,          32'h12345678, 4'b1111, 1, 1'b0, 1'b0, 32'h0, "a_sw0");
        req(1'b0, 1'b1, 1'b0, BA + 32'd3,  32'h0000FFFF, 4'b0011, 1, 1'b1, 1'b0, 32'h0, "a_sh3");
        req(1'b0, 1'b0, 1'b1, BA,          32'h0,        4'b1111, 2, 1'b0, 1'b1, 32'h12345678, "a_lw0");
        req(1'b0, 1'b0, 1'b1, BA + 32'h1000, 32'h0,      4'b1111, 2, 1'b1, 1'b1, 32'h0, "a_lw_oor");
        req(1'b0, 1'b1, 1'b1, BA + 32'd8,  32'h0,        4'b1111, 1, 1'b1, 1'b0, 32'h0, "a_both");
        req(1'b0, 1'b0, 1'b1, BA + 32'd8,  32'h0,        4'b1111, 2, 1'b0, 1'b1, 32'hDEADAAEF, "a_lw8c");
        req(1'b0, 1'b1, 1'b0, BA + 32'd1,  32'h55555555, 4'b1111, 1, 1'b1, 1'b0, 32'h0, "a_sw1");
        req(1'b0, 1'b0, 1'b1, BA + 32'd3,  32'h0,        4'b0011, 2, 1'b1, 1'b1, 32'h0, "a_lh3");
        req(1'b0, 1'b0, 1'b1, BA - 32'd4,  32'h0,        4'b1111, 2, 1'b1, 1'b1, 32'h0, "a_lw_below");
        req(1'b0, 1'b0, 1'b1, BA + 32'd8,  32'h0,        4'b1111, 2, 1'b0, 1'b1, 32'hDEADAAEF, "a_lw8d");

        // Instance B: RL=1, WL=4, window 0x40..0x7F
        req(1'b1, 1'b1, 1'b0, 32'h44, 32'hCAFEF00D, 4'b1111, 4, 1'b0, 1'b0, 32'h0, "b_sw44");
        req(1'b1, 1'b1, 1'b0, 32'h48, 32'h11223344, 4'b1111, 4, 1'b0, 1'b0, 32'h0, "b_sw48");
        req(1'b1, 1'b0, 1'b1, 32'h48, 32'h0,        4'b1111, 1, 1'b0, 1'b1, 32'h11223344, "b_lw48");
        req(1'b1, 1'b1, 1'b0, 32'h80, 32'h0,        4'b1111, 4, 1'b1, 1'b0, 32'h0, "b_sw_oor");

        // Enable held across three loads: pulses in cycles 1, 3, 5 only
        drive(1'b1, 1'b0, 1'b1, 32'h44, 32'h0, 4'b1111);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            sample(1'b1, wr, rv, flt, rd);
            check($sformatf("b_b2b.c%0d.read_valid", i), {31'd0, rv}, {31'd0, (i == 1 || i == 3 || i == 5)});
            if (i == 1) begin
                check("b_b2b.c1.rdata", rd, 32'hCAFEF00D);
                b_addr = 32'h48;
            end else if (i == 3) begin
                check("b_b2b.c3.rdata", rd, 32'h11223344);
                b_addr = 32'h44;
            end else if (i == 5) begin
                check("b_b2b.c5.rdata", rd, 32'hCAFEF00D);
                b_re = 1'b0;
            end
        end

        // Reset during WAIT of a store drops the store
        drive(1'b1, 1'b1, 1'b0, 32'h44, 32'hBAD0BAD0, 4'b1111);
        @(posedge clk); #1;
        check("b_rst.c1.write_ready", {31'd0, b_wr}, 32'd0);
        @(posedge clk); #1;
        b_rst_n = 1'b0;
        #1;
        check("b_rst.outs", {29'd0, b_wr, b_rv, b_flt}, 32'd0);
        check("b_rst.rdata", b_rdata, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 2) b_rst_n = 1'b1;
            check($sformatf("b_rst.quiet%0d", i), {30'd0, b_wr, b_rv}, 32'd0);
        end
        req(1'b1, 1'b0, 1'b1, 32'h44, 32'h0, 4'b1111, 1, 1'b0, 1'b1, 32'hCAFEF00D, "b_lw44_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
